// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter and transfer sequencer for the shared packet bus.
// It pops one packet from the granted driver FIFO and delivers it one-hot or broadcast.
module bus_rr_arbiter #(
  parameter int unsigned drvrs     = 4,
  parameter int unsigned pckg_sz   = 16,
  parameter logic [7:0]  broadcast = 8'hFF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [drvrs-1:0]           pndng,
  input  logic [drvrs*pckg_sz-1:0]   D_pop,
  output logic [drvrs-1:0]           pop,
  output logic [drvrs-1:0]           push,
  output logic [pckg_sz-1:0]         D_push,
  output logic                       busy,
  output logic [$clog2(drvrs)-1:0]   grant_id,
  output logic                       drop,
  output logic [15:0]                pkt_count
);

  localparam int unsigned GW = $clog2(drvrs);

  typedef enum logic [1:0] {StIdle, StPop, StPush} state_e;

  state_e               state_q, state_d;
  logic [GW-1:0]        last_q, last_d;
  logic [GW-1:0]        grant_q, grant_d;
  logic [drvrs-1:0]     push_q, push_d;
  logic [pckg_sz-1:0]   data_q, data_d;
  logic                 drop_q, drop_d;
  logic [15:0]          cnt_q, cnt_d;

  logic [pckg_sz-1:0]   slot [drvrs];
  logic [pckg_sz-1:0]   head;
  logic [7:0]           dest;
  logic                 rr_found;
  logic [GW-1:0]        rr_idx;
  logic [31:0]          rr_scan;

  for (genvar i = 0; i < drvrs; i++) begin : g_slot
    assign slot[i] = D_pop[i*pckg_sz +: pckg_sz];
  end

  assign head = slot[grant_q];
  assign dest = head[pckg_sz-1 -: 8];

  // First pending driver after the last grant, wrapping around.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_scan  = '0;
    for (int unsigned k = 1; k <= drvrs; k++) begin
      rr_scan = (32'(last_q) + k) % drvrs;
      if (!rr_found && pndng[GW'(rr_scan)]) begin
        rr_found = 1'b1;
        rr_idx   = GW'(rr_scan);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    push_d  = '0;
    data_d  = data_q;
    drop_d  = 1'b0;
    cnt_d   = cnt_q;
    pop     = '0;
    unique case (state_q)
      StIdle: begin
        if (rr_found) begin
          grant_d = rr_idx;
          last_d  = rr_idx;
          state_d = StPop;
        end
      end
      StPop: begin
        pop[grant_q] = pndng[grant_q];
        if (pndng[grant_q]) begin
          data_d  = head;
          state_d = StPush;
          if (32'(dest) < drvrs) begin
            push_d[dest[GW-1:0]] = 1'b1;
          end else if (dest == broadcast) begin
            push_d          = '1;
            push_d[grant_q] = 1'b0;
          end else begin
            drop_d = 1'b1;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StPush: begin
        state_d = StIdle;
        if (|push_q) cnt_d = cnt_q + 16'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      last_q  <= GW'(drvrs - 1);
      grant_q <= '0;
      push_q  <= '0;
      data_q  <= '0;
      drop_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      push_q  <= push_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
      cnt_q   <= cnt_d;
    end
  end

  assign push      = push_q;
  assign D_push    = data_q;
  assign busy      = (state_q != StIdle);
  assign grant_id  = grant_q;
  assign drop      = drop_q;
  assign pkt_count = cnt_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Randomized bench for bus_rr_arbiter with a transaction-level reference model.
module tb_bus_rr_arbiter;

  localparam int unsigned D = 4;
  localparam int unsigned P = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [D-1:0]     pndng;
  logic [D*P-1:0]   D_pop;
  logic [D-1:0]     pop;
  logic [D-1:0]     push;
  logic [P-1:0]     D_push;
  logic             busy;
  logic [1:0]       grant_id;
  logic             drop;
  logic [15:0]      pkt_count;

  always #5 clk = ~clk;

  bus_rr_arbiter #(.drvrs(D), .pckg_sz(P), .broadcast(8'hFF)) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .pop(pop), .push(push),
    .D_push(D_push), .busy(busy), .grant_id(grant_id), .drop(drop), .pkt_count(pkt_count)
  );

  int total = 0;
  int bad   = 0;

  // Model: phase 0 = arbitrating, 1 = fetching from the granted FIFO, 2 = delivering.
  int           m_phase;
  int           m_last;
  int           m_grant;
  int           m_cnt;
  logic [D-1:0] m_push;
  logic [P-1:0] m_dpush;
  logic         m_drop;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_last  = D - 1;
    m_grant = 0;
    m_cnt   = 0;
    m_push  = '0;
    m_dpush = '0;
    m_drop  = 1'b0;
  endtask

  task automatic model_update(input logic [D-1:0] p, input logic [D*P-1:0] d, input logic r);
    logic [P-1:0] pkt;
    int           dst;
    bit           found;
    if (r) begin
      model_reset();
      return;
    end
    case (m_phase)
      0: begin
        found = 0;
        for (int k = 1; k <= D; k++) begin
          int i;
          i = (m_last + k) % D;
          if (!found && p[i]) begin
            found   = 1;
            m_grant = i;
            m_last  = i;
            m_phase = 1;
          end
        end
        m_push = '0;
        m_drop = 1'b0;
      end
      1: begin
        m_push = '0;
        m_drop = 1'b0;
        if (p[m_grant]) begin
          pkt     = d[m_grant*P +: P];
          m_dpush = pkt;
          dst     = int'(pkt[P-1 -: 8]);
          if (dst < D) m_push = D'(1 << dst);
          else if (dst == 255) m_push = D'(((1 << D) - 1) & ~(1 << m_grant));
          else m_drop = 1'b1;
          m_phase = 2;
        end else begin
          m_phase = 0;
        end
      end
      default: begin
        if (m_push != 0) m_cnt = (m_cnt + 1) % 65536;
        m_push  = '0;
        m_drop  = 1'b0;
        m_phase = 0;
      end
    endcase
  endtask

  task automatic check_outputs();
    check("busy", 32'(busy), 32'(m_phase != 0));
    check("grant_id", 32'(grant_id), 32'(m_grant));
    check("push", 32'(push), 32'(m_push));
    check("drop", 32'(drop), 32'(m_drop));
    check("D_push", 32'(D_push), 32'(m_dpush));
    check("pkt_count", 32'(pkt_count), 32'(m_cnt));
  endtask

  // One bus cycle: check registered outputs, apply inputs, check pop, then advance the model.
  task automatic step(input logic [D-1:0] p, input logic [D*P-1:0] d, input logic r);
    logic [D-1:0] exp_pop;
    @(negedge clk);
    check_outputs();
    pndng = p;
    D_pop = d;
    reset = r;
    #1;
    exp_pop = (m_phase == 1 && p[m_grant]) ? D'(1 << m_grant) : '0;
    check("pop", 32'(pop), 32'(exp_pop));
    @(posedge clk);
    model_update(p, d, r);
  endtask

  function automatic logic [D*P-1:0] rand_data();
    logic [D*P-1:0] v;
    int sel;
    logic [7:0] dst;
    for (int i = 0; i < D; i++) begin
      sel = $urandom_range(0, 5);
      if (sel < 4) dst = 8'(sel);
      else if (sel == 4) dst = 8'hFF;
      else dst = 8'($urandom_range(4, 254));
      v[i*P +: P] = {dst, 8'($urandom)};
    end
    return v;
  endfunction

  logic [D*P-1:0] dv;

  initial begin
    reset = 1'b1;
    pndng = '0;
    D_pop = '0;
    repeat (2) @(posedge clk);
    model_reset();

    // Single request from driver 2 addressed to driver 1.
    dv = '0;
    dv[2*P +: P] = 16'h01AB;
    step(4'b0000, dv, 1'b0);
    step(4'b0100, dv, 1'b0);
    step(4'b0100, dv, 1'b0);
    #1;
    check("single_push", 32'(push), 32'h2);
    check("single_data", 32'(D_push), 32'h01AB);
    step(4'b0000, dv, 1'b0);
    #1;
    check("single_cnt", 32'(pkt_count), 32'd1);

    // Broadcast from driver 1.
    dv = '0;
    dv[1*P +: P] = 16'hFF55;
    step(4'b0010, dv, 1'b0);
    step(4'b0010, dv, 1'b0);
    #1;
    check("bcast_push", 32'(push), 32'hD);
    check("bcast_data", 32'(D_push), 32'hFF55);
    step(4'b0000, dv, 1'b0);
    #1;
    check("bcast_cnt", 32'(pkt_count), 32'd2);

    // Invalid destination from driver 3.
    dv = '0;
    dv[3*P +: P] = 16'h0700;
    step(4'b1000, dv, 1'b0);
    step(4'b1000, dv, 1'b0);
    #1;
    check("inval_push", 32'(push), 32'h0);
    check("inval_drop", 32'(drop), 32'h1);
    step(4'b0000, dv, 1'b0);
    #1;
    check("inval_drop_end", 32'(drop), 32'h0);
    check("inval_cnt", 32'(pkt_count), 32'd2);

    // Pending withdrawn in the fetch cycle.
    step(4'b0001, dv, 1'b0);
    step(4'b0000, dv, 1'b0);
    #1;
    check("withdraw_idle", 32'(busy), 32'h0);
    check("withdraw_push", 32'(push), 32'h0);

    // Reset during fetch; driver 0 wins afterwards.
    step(4'b1111, dv, 1'b0);
    step(4'b1111, dv, 1'b1);
    #1;
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_cnt", 32'(pkt_count), 32'h0);
    step(4'b1111, dv, 1'b0);
    #1;
    check("rst_regrant", 32'(grant_id), 32'h0);

    // Everyone requesting continuously, all addressed to driver 0.
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < D; i++) dv[i*P +: P] = {8'h00, 8'($urandom)};
      step(4'b1111, dv, 1'b0);
    end

    // Random traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      step(D'($urandom), rand_data(), ($urandom_range(0, 60) == 0));
    end

    @(negedge clk);
    check_outputs();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
